// File: rtl/activation_row_streamer_pkg.sv
// Shared types and sizing helpers for the activation row streamer.
// Word ordering here must match the write-side packer.
package activation_row_streamer_pkg;

  localparam int ACT_WIDTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAKE,
    FETCH,
    WAIT,
    STREAM
  } state_t;

  function automatic int words_per_row(
    input int width,
    input int act_width
  );
    return width / act_width;
  endfunction

  function automatic int count_width(
    input int num_rows,
    input int width,
    input int act_width
  );
    return $clog2(num_rows * words_per_row(width, act_width) + 1);
  endfunction

endpackage

// File: rtl/activation_row_streamer_if.sv
// Memory read port and activation stream bundle.
// The master side is the streamer; the slave side is memory plus consumer.
interface activation_row_streamer_if
  import activation_row_streamer_pkg::*;
#(
  parameter int WIDTH         = 1024,
  parameter int ADDRESS_WIDTH = 7,
  parameter int ACT_WIDTH     = ACT_WIDTH_DEFAULT
);

  logic [ADDRESS_WIDTH-1:0] address_read;
  logic                     read_enable;
  logic                     power_down;
  logic [WIDTH-1:0]         mem_data;
  logic [ACT_WIDTH-1:0]     act_data;
  logic                     act_valid;
  logic                     act_ready;
  logic                     act_last;

  modport master (
    output address_read,
    output read_enable,
    output power_down,
    output act_data,
    output act_valid,
    output act_last,
    input  mem_data,
    input  act_ready
  );

  modport slave (
    input  address_read,
    input  read_enable,
    input  power_down,
    input  act_data,
    input  act_valid,
    input  act_last,
    output mem_data,
    output act_ready
  );

endinterface

// File: rtl/activation_row_streamer_unpacker.sv
// Row register and word selector; word 0 sits in the row LSBs.
// act_data is a flop so the streamed word is glitch-free.
module activation_row_unpacker
  import activation_row_streamer_pkg::*;
#(
  parameter int WIDTH     = 1024,
  parameter int ACT_WIDTH = ACT_WIDTH_DEFAULT,
  localparam int WPR      = words_per_row(WIDTH, ACT_WIDTH),
  localparam int IDX_W    = (WPR > 1) ? $clog2(WPR) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [WIDTH-1:0]     mem_data,
  output logic [ACT_WIDTH-1:0] act_data,
  output logic                 row_exhausted
);

  logic [WPR-1:0][ACT_WIDTH-1:0] row_q;
  logic [IDX_W-1:0]              idx_q;
  logic [IDX_W-1:0]              idx_nxt;

  assign idx_nxt       = idx_q + IDX_W'(1);
  assign row_exhausted = (idx_q == IDX_W'(WPR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q    <= '0;
      idx_q    <= '0;
      act_data <= '0;
    end else if (load) begin
      row_q    <= mem_data;
      idx_q    <= '0;
      act_data <= mem_data[ACT_WIDTH-1:0];
    end else if (advance) begin
      idx_q    <= idx_nxt;
      act_data <= row_q[idx_nxt];
    end
  end

endmodule

// File: rtl/activation_row_streamer.sv
// Streams activation rows from the SRAM read port to the datapath.
// Also owns read-port power-down after a run of idle cycles.
module activation_row_streamer
  import activation_row_streamer_pkg::*;
#(
  parameter int WIDTH         = 1024,
  parameter int NUM_ROWS      = 128,
  parameter int ACT_WIDTH     = ACT_WIDTH_DEFAULT,
  parameter int PD_DELAY      = 16,
  localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS),
  localparam int COUNT_WIDTH   =
    count_width(NUM_ROWS, WIDTH, ACT_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_row,
  input  logic [COUNT_WIDTH-1:0]   num_words,
  output logic                     busy,
  output logic                     done,
  activation_row_streamer_if.master bus
);

  localparam int IDLE_W = $clog2(PD_DELAY + 1);

  state_t                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     rd_en_q, rd_en_d;
  logic                     pd_q, pd_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic [ADDRESS_WIDTH-1:0] row_q, row_d;
  logic [COUNT_WIDTH-1:0]   rem_q, rem_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic                     load;
  logic                     advance;
  logic                     exhausted;
  logic                     hs;

  assign hs = valid_q & bus.act_ready;

  activation_row_unpacker #(
    .WIDTH     (WIDTH),
    .ACT_WIDTH (ACT_WIDTH)
  ) u_unpacker (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .advance       (advance),
    .mem_data      (bus.mem_data),
    .act_data      (bus.act_data),
    .row_exhausted (exhausted)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    pd_d    = pd_q;
    valid_d = valid_q;
    last_d  = last_q;
    row_d   = row_q;
    rem_d   = rem_q;
    idle_d  = idle_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idle_d = '0;
          pd_d   = 1'b0;
          if (num_words == '0) begin
            done_d = 1'b1;
          end else begin
            row_d  = start_row;
            rem_d  = num_words;
            busy_d = 1'b1;
            if (pd_q) begin
              state_d = WAKE;
            end else begin
              state_d = FETCH;
              rd_en_d = 1'b1;
            end
          end
        end else if (idle_q != IDLE_W'(PD_DELAY)) begin
          idle_d = idle_q + IDLE_W'(1);
          pd_d   = (idle_d == IDLE_W'(PD_DELAY));
        end
      end
      WAKE: begin
        state_d = FETCH;
        rd_en_d = 1'b1;
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        load    = 1'b1;
        valid_d = 1'b1;
        last_d  = (rem_q == COUNT_WIDTH'(1));
        state_d = STREAM;
      end
      STREAM: begin
        if (hs) begin
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (rem_q == COUNT_WIDTH'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else if (exhausted) begin
            // wrap explicitly so non-power-of-two depths also work
            if (row_q == ADDRESS_WIDTH'(NUM_ROWS - 1)) begin
              row_d = '0;
            end else begin
              row_d = row_q + ADDRESS_WIDTH'(1);
            end
            state_d = FETCH;
            rd_en_d = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            advance = 1'b1;
            last_d  = (rem_q == COUNT_WIDTH'(2));
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      pd_q    <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      rem_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      pd_q    <= pd_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
      idle_q  <= idle_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.address_read = row_q;
  assign bus.read_enable  = rd_en_q;
  assign bus.power_down   = pd_q;
  assign bus.act_valid    = valid_q;
  assign bus.act_last     = last_q;

endmodule
